// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared yAdder1 cell adds two W-bit operands LSB-first over W cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module yAdder1 (
   output logic z,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic c
);
   assign z    = a ^ b ^ c;
   assign cout = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int W  = 8,
   parameter int CW = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic         ovf,
`endif
   output logic         cout
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   sha_q, sha_d, shb_q, shb_d, res_q, res_d, sum_q, sum_d;
   logic           carry_q, carry_d, cout_q, cout_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           z, co, last;

   yAdder1 u_add (.z(z), .cout(co), .a(sha_q[0]), .b(shb_q[0]), .c(carry_q));

   assign last = (cnt_q == CW'(W-1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last)  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // Datapath: operands load on an accepted start and shift once per RUN cycle.
   always_comb begin
      sha_d   = sha_q;
      shb_d   = shb_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (state_q == S_IDLE && start) begin
         sha_d   = a;
         shb_d   = b;
         carry_d = cin;
         cnt_d   = '0;
      end else if (state_q == S_RUN) begin
         sha_d   = {1'b0, sha_q[W-1:1]};
         shb_d   = {1'b0, shb_q[W-1:1]};
         res_d   = {z, res_q[W-1:1]};
         carry_d = co;
         cnt_d   = cnt_q + 1'b1;
         if (last) begin
            sum_d  = {z, res_q[W-1:1]};
            cout_d = co;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sha_q   <= '0;
         shb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
   // carry_q in the last RUN cycle is the carry into the MSB.
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (rst)                          ovf_q <= 1'b0;
      else if (state_q == S_RUN && last) ovf_q <= carry_q ^ co;
   end
   assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: W=8 directed cases plus exhaustive W=4.
module tb_serial_add_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start8, cin8, start4, cin4;
   logic [7:0] a8, b8;
   logic [3:0] a4, b4;
   logic       busy8, done8, cout8, busy4, done4, cout4;
   logic [7:0] sum8;
   logic [3:0] sum4;
   logic       ovf8_s, ovf4_s;
`ifdef SERIAL_ADD_OVF_EN
   logic       ovf8, ovf4;
   assign ovf8_s = ovf8;
   assign ovf4_s = ovf4;
`else
   assign ovf8_s = 1'b0;
   assign ovf4_s = 1'b0;
`endif

   serial_add_ctrl #(.W(8), .CW(5)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADD_OVF_EN
      .ovf(ovf8),
`endif
      .cout(cout8));

   serial_add_ctrl #(.W(4), .CW(3)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4),
`ifdef SERIAL_ADD_OVF_EN
      .ovf(ovf4),
`endif
      .cout(cout4));

   int nchk = 0, nerr = 0;
   int dcnt8 = 0;
   logic [9:0] q8[$];
   logic [5:0] q4[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {ovf,cout,sum}; ovf from carry into MSB vs carry out.
   function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
      logic [8:0] full;
      logic [7:0] low;
      logic       ov;
      full = {1'b0, x} + {1'b0, y} + {8'd0, c};
      low  = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'd0, c};
`ifdef SERIAL_ADD_OVF_EN
      ov = low[7] ^ full[8];
`else
      ov = 1'b0;
`endif
      return {ov, full};
   endfunction

   function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
      logic [4:0] full;
      logic [3:0] low;
      logic       ov;
      full = {1'b0, x} + {1'b0, y} + {4'd0, c};
      low  = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'd0, c};
`ifdef SERIAL_ADD_OVF_EN
      ov = low[3] ^ full[4];
`else
      ov = 1'b0;
`endif
      return {ov, full};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (busy8 && done8) check("busy_done_overlap8", 1, 0);
         if (busy4 && done4) check("busy_done_overlap4", 1, 0);
         if (done8) begin
            dcnt8++;
            if (q8.size() == 0) check("spurious_done8", 1, 0);
            else check("result8", {ovf8_s, cout8, sum8}, q8.pop_front());
         end
         if (done4) begin
            if (q4.size() == 0) check("spurious_done4", 1, 0);
            else check("result4", {ovf4_s, cout4, sum4}, q4.pop_front());
         end
      end
   end

   // Called at a negedge with the DUT idle; returns after done is seen.
   task automatic add8(input logic [7:0] x, input logic [7:0] y, input logic c, output int bc);
      bit seen = 0;
      a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
      q8.push_back(model8(x, y, c));
      bc = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (done8) seen = 1;
         else if (busy8) bc++;
      end
      if (!seen) check("timeout8", 0, 1);
   endtask

   task automatic add4(input logic [3:0] x, input logic [3:0] y, input logic c);
      bit seen = 0;
      a4 = x; b4 = y; cin4 = c; start4 = 1'b1;
      q4.push_back(model4(x, y, c));
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (done4) seen = 1;
      end
      if (!seen) check("timeout4", 0, 1);
   endtask

   initial begin
      int bc, d0;
      bit seen;
      rst = 1'b1; start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      start4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_busy", busy8, 0);
         check("rst_done", done8, 0);
         check("rst_sum", sum8, 0);
         check("rst_cout", cout8, 0);
      end
      rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
      @(negedge clk);

      add8(8'h35, 8'h4A, 1'b0, bc);
      check("busy_cycles", bc, 8);
      @(negedge clk);
      check("done_one_cycle", done8, 0);

      add8(8'hFF, 8'h01, 1'b1, bc);
      @(negedge clk);
      add8(8'h7F, 8'h01, 1'b0, bc);
      @(negedge clk);
      add8(8'h80, 8'h80, 1'b0, bc);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         add8(8'($urandom), 8'($urandom), 1'($urandom), bc);
         @(negedge clk);
      end

      // start pulsed mid-run with new operands, operands wiggled: must be ignored
      d0 = dcnt8;
      a8 = 8'hA5; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
      q8.push_back(model8(8'hA5, 8'h3C, 1'b1));
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         start8 = (i == 3);
         if (i >= 3) begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); end
         if (done8) seen = 1;
      end
      start8 = 1'b0;
      if (!seen) check("timeout_ignore", 0, 1);
      repeat (12) @(negedge clk);
      check("one_done_pulse", dcnt8 - d0, 1);

      // reset at the 4th RUN cycle aborts without a done pulse
      a8 = 8'h55; b8 = 8'h66; cin8 = 1'b0; start8 = 1'b1;
      bc = 0;
      for (int i = 0; i < 60 && bc < 4; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         if (busy8) bc++;
      end
      d0 = dcnt8;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy8, 0);
      check("abort_sum", sum8, 0);
      check("abort_cout", cout8, 0);
      repeat (12) @(negedge clk);
      check("abort_no_done", dcnt8 - d0, 0);
      add8(8'h10, 8'h20, 1'b0, bc);
      @(negedge clk);

      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++) begin
               add4(4'(x), 4'(y), 1'(c));
               @(negedge clk);
            end

      repeat (4) @(negedge clk);
      check("q8_drained", q8.size(), 0);
      check("q4_drained", q4.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
